// File: rtl/esfa_pkg.sv
// Shared definitions for the ESFA cell sequencer: opcodes, write mask,
// sequencer state encoding and opcode classification helpers.
package esfa_pkg;

    localparam logic [7:0] OP_UPDATE      = 8'd0;
    localparam logic [7:0] OP_LOOKUP      = 8'd1;
    localparam logic [7:0] OP_ENCODE      = 8'd2;
    localparam logic [7:0] OP_CONGRUEUP   = 8'd3;
    localparam logic [7:0] OP_CONGRUEDOWN = 8'd4;
    localparam logic [7:0] OP_MARKAVAIL   = 8'd5;
    localparam logic [7:0] OP_ENRANK      = 8'd6;
    localparam logic [7:0] OP_ENRANGE     = 8'd7;

    // Ops allowed to write cell state: update, congrueUp, congrueDown
    localparam logic [7:0] OP_WRITE_MASK  = 8'b0001_1001;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_ISSUE,
        SEQ_CAPTURE,
        SEQ_RESP
    } seq_state_e;

    function automatic logic op_legal(input logic [7:0] op);
        return op <= OP_ENRANGE;
    endfunction

    function automatic logic op_writes(input logic [7:0] op);
        return op_legal(op) && OP_WRITE_MASK[op[2:0]];
    endfunction

endpackage

// File: rtl/esfa_result_reducer.sv
// Combinational reduction of per-cell results: hit flag, lowest-index
// priority encode, popcount and value/context mux of the winning cell.
// Ports: cell_bool_i/value_i/context_i in; hit_o, cell_o, value_o,
// context_o, count_o out.
module esfa_result_reducer #(
    parameter int NUM_CELLS = 8,
    parameter int IDX_W     = 3
) (
    input  logic [NUM_CELLS-1:0]   cell_bool_i,
    input  logic [8*NUM_CELLS-1:0] cell_value_i,
    input  logic [8*NUM_CELLS-1:0] cell_context_i,
    output logic                   hit_o,
    output logic [IDX_W-1:0]       cell_o,
    output logic [7:0]             value_o,
    output logic [7:0]             context_o,
    output logic [IDX_W:0]         count_o
);

    always_comb begin
        hit_o     = |cell_bool_i;
        cell_o    = '0;
        value_o   = '0;
        context_o = '0;
        count_o   = '0;
        // Walk high to low so the lowest set index wins
        for (int i = NUM_CELLS - 1; i >= 0; i--) begin
            if (cell_bool_i[i]) begin
                cell_o    = IDX_W'(i);
                value_o   = cell_value_i[8*i +: 8];
                context_o = cell_context_i[8*i +: 8];
            end
        end
        for (int i = 0; i < NUM_CELLS; i++) begin
            count_o = count_o + (IDX_W + 1)'(cell_bool_i[i]);
        end
    end

endmodule

// File: rtl/esfa_cell_sequencer.sv
// Command sequencer for the ESFA cell bank: accepts one op, broadcasts it,
// pulses write-enable, captures the reduced cell results and returns them.
// Ports: cmd_* handshake in, cell_* broadcast out, cell results in,
// rsp_* handshake out.
module esfa_cell_sequencer
    import esfa_pkg::*;
#(
    parameter int NUM_CELLS = 8,
    parameter int IDX_W     = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [7:0]             cmd_op,
    input  logic                   cmd_write,
    input  logic [7:0]             cmd_handle,
    input  logic [7:0]             cmd_index,
    input  logic [7:0]             cmd_value,
    input  logic [7:0]             cmd_metadata,
    input  logic                   cmd_is_meta,
    output logic [7:0]             cell_selector,
    output logic                   cell_will_write,
    output logic [7:0]             cell_handle,
    output logic [7:0]             cell_inserted_index,
    output logic [7:0]             cell_inserted_value,
    output logic [7:0]             cell_metadata,
    output logic                   cell_is_metadata,
    input  logic [NUM_CELLS-1:0]   cell_bool,
    input  logic [8*NUM_CELLS-1:0] cell_value,
    input  logic [8*NUM_CELLS-1:0] cell_context,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_hit,
    output logic                   rsp_err,
    output logic [IDX_W-1:0]       rsp_cell,
    output logic [7:0]             rsp_value,
    output logic [7:0]             rsp_context,
    output logic [IDX_W:0]         rsp_hit_count,
    output logic [7:0]             rsp_op
);

    seq_state_e       state_q;
    logic [7:0]       sel_q, hdl_q, idx_q, val_q, meta_q, op_q;
    logic             is_meta_q, we_q;
    logic             valid_q, hit_q, err_q;
    logic [IDX_W-1:0] cell_q;
    logic [7:0]       rval_q, rctx_q;
    logic [IDX_W:0]   cnt_q;

    logic             red_hit;
    logic [IDX_W-1:0] red_cell;
    logic [7:0]       red_value, red_context;
    logic [IDX_W:0]   red_count;

    esfa_result_reducer #(
        .NUM_CELLS (NUM_CELLS),
        .IDX_W     (IDX_W)
    ) u_reducer (
        .cell_bool_i    (cell_bool),
        .cell_value_i   (cell_value),
        .cell_context_i (cell_context),
        .hit_o          (red_hit),
        .cell_o         (red_cell),
        .value_o        (red_value),
        .context_o      (red_context),
        .count_o        (red_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SEQ_IDLE;
            sel_q     <= '0;
            hdl_q     <= '0;
            idx_q     <= '0;
            val_q     <= '0;
            meta_q    <= '0;
            is_meta_q <= 1'b0;
            we_q      <= 1'b0;
            op_q      <= '0;
            valid_q   <= 1'b0;
            hit_q     <= 1'b0;
            err_q     <= 1'b0;
            cell_q    <= '0;
            rval_q    <= '0;
            rctx_q    <= '0;
            cnt_q     <= '0;
        end else begin
            unique case (state_q)
                SEQ_IDLE: begin
                    if (cmd_valid) begin
                        sel_q     <= cmd_op;
                        hdl_q     <= cmd_handle;
                        idx_q     <= cmd_index;
                        val_q     <= cmd_value;
                        meta_q    <= cmd_metadata;
                        is_meta_q <= cmd_is_meta;
                        op_q      <= cmd_op;
                        if (!op_legal(cmd_op)) begin
                            // Illegal ops skip the cells entirely
                            state_q <= SEQ_RESP;
                            valid_q <= 1'b1;
                            err_q   <= 1'b1;
                            hit_q   <= 1'b0;
                            cell_q  <= '0;
                            rval_q  <= '0;
                            rctx_q  <= '0;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= SEQ_ISSUE;
                            we_q    <= cmd_write & op_writes(cmd_op);
                        end
                    end
                end
                SEQ_ISSUE: begin
                    we_q    <= 1'b0;
                    state_q <= SEQ_CAPTURE;
                end
                SEQ_CAPTURE: begin
                    valid_q <= 1'b1;
                    err_q   <= 1'b0;
                    hit_q   <= red_hit;
                    cell_q  <= red_cell;
                    rval_q  <= red_value;
                    rctx_q  <= red_context;
                    cnt_q   <= red_count;
                    state_q <= SEQ_RESP;
                end
                SEQ_RESP: begin
                    if (rsp_ready) begin
                        valid_q <= 1'b0;
                        state_q <= SEQ_IDLE;
                    end
                end
                default: state_q <= SEQ_IDLE;
            endcase
        end
    end

    // Held low while reset is asserted so nothing is accepted mid-reset
    assign cmd_ready           = rst_n & (state_q == SEQ_IDLE);
    assign cell_selector       = sel_q;
    assign cell_will_write     = we_q;
    assign cell_handle         = hdl_q;
    assign cell_inserted_index = idx_q;
    assign cell_inserted_value = val_q;
    assign cell_metadata       = meta_q;
    assign cell_is_metadata    = is_meta_q;
    assign rsp_valid           = valid_q;
    assign rsp_hit             = hit_q;
    assign rsp_err             = err_q;
    assign rsp_cell            = cell_q;
    assign rsp_value           = rval_q;
    assign rsp_context         = rctx_q;
    assign rsp_hit_count       = cnt_q;
    assign rsp_op              = op_q;

endmodule

// File: tb/tb_esfa_cell_sequencer.sv
// Directed self-checking bench for esfa_cell_sequencer.
// One task per scenario, inline comparisons, single summary line.
module tb_esfa_cell_sequencer;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [7:0]   cmd_op;
    logic         cmd_write;
    logic [7:0]   cmd_handle, cmd_index, cmd_value, cmd_metadata;
    logic         cmd_is_meta;
    logic [7:0]   cell_selector;
    logic         cell_will_write;
    logic [7:0]   cell_handle, cell_inserted_index;
    logic [7:0]   cell_inserted_value, cell_metadata;
    logic         cell_is_metadata;
    logic [N-1:0] cell_bool;
    logic [8*N-1:0] cell_value, cell_context;
    logic         rsp_valid, rsp_ready, rsp_hit, rsp_err;
    logic [W-1:0] rsp_cell;
    logic [7:0]   rsp_value, rsp_context, rsp_op;
    logic [W:0]   rsp_hit_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    esfa_cell_sequencer #(.NUM_CELLS(N), .IDX_W(W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_op              (cmd_op),
        .cmd_write           (cmd_write),
        .cmd_handle          (cmd_handle),
        .cmd_index           (cmd_index),
        .cmd_value           (cmd_value),
        .cmd_metadata        (cmd_metadata),
        .cmd_is_meta         (cmd_is_meta),
        .cell_selector       (cell_selector),
        .cell_will_write     (cell_will_write),
        .cell_handle         (cell_handle),
        .cell_inserted_index (cell_inserted_index),
        .cell_inserted_value (cell_inserted_value),
        .cell_metadata       (cell_metadata),
        .cell_is_metadata    (cell_is_metadata),
        .cell_bool           (cell_bool),
        .cell_value          (cell_value),
        .cell_context        (cell_context),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_hit             (rsp_hit),
        .rsp_err             (rsp_err),
        .rsp_cell            (rsp_cell),
        .rsp_value           (rsp_value),
        .rsp_context         (rsp_context),
        .rsp_hit_count       (rsp_hit_count),
        .rsp_op              (rsp_op)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cell i returns value A0+i and context C0+i by default
    task automatic load_cells(input logic [N-1:0] b);
        cell_bool = b;
        for (int i = 0; i < N; i++) begin
            cell_value[8*i +: 8]   = 8'hA0 + 8'(i);
            cell_context[8*i +: 8] = 8'hC0 + 8'(i);
        end
    endtask

    // Present a command, let it be taken at the next edge, then drop valid
    task automatic send(input logic [7:0] op, input logic wr,
                        input logic [7:0] h, input logic [7:0] v);
        cmd_valid    = 1'b1;
        cmd_op       = op;
        cmd_write    = wr;
        cmd_handle   = h;
        cmd_index    = 8'h11;
        cmd_value    = v;
        cmd_metadata = 8'h33;
        cmd_is_meta  = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_op = '0; cmd_write = 1'b0;
        cmd_handle = '0; cmd_index = '0;
        cmd_value = '0; cmd_metadata = '0;
        cmd_is_meta = 1'b0;
        load_cells('0);
        #12;
        n_cmp++;
        if ({rsp_valid, cell_will_write, cell_selector, rsp_op}
            !== 18'd0) begin
            n_bad++;
            $display("FAIL reset_outs: got %h want 0",
                {rsp_valid, cell_will_write, cell_selector, rsp_op});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_update_write();
        logic [7:0] snap;
        load_cells(8'b0000_1000);
        cell_value[8*3 +: 8]   = 8'h2A;
        cell_context[8*3 +: 8] = 8'h05;
        send(8'd0, 1'b1, 8'h05, 8'h2A);
        n_cmp++;
        if ({cell_will_write, cell_handle, cell_inserted_value, cmd_ready}
            !== {1'b1, 8'h05, 8'h2A, 1'b0}) begin
            n_bad++;
            $display("FAIL upd_issue: got %b %h %h %b want 1 05 2a 0",
                cell_will_write, cell_handle, cell_inserted_value,
                cmd_ready);
        end
        step();
        n_cmp++;
        if ({cell_will_write, rsp_valid, cell_handle} !== {2'b00, 8'h05})
        begin
            n_bad++;
            $display("FAIL upd_capture: got we=%b v=%b h=%h want 0 0 05",
                cell_will_write, rsp_valid, cell_handle);
        end
        step();
        n_cmp++;
        if ({rsp_valid, rsp_hit, rsp_err, rsp_cell, rsp_value,
             rsp_context, rsp_hit_count, rsp_op}
            !== {3'b110, 3'd3, 8'h2A, 8'h05, 4'd1, 8'd0}) begin
            n_bad++;
            $display("FAIL upd_rsp: got v%b h%b e%b c%0d %h %h n%0d op%0d",
                rsp_valid, rsp_hit, rsp_err, rsp_cell, rsp_value,
                rsp_context, rsp_hit_count, rsp_op);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        snap = cell_handle;
        n_cmp++;
        if ({rsp_valid, cmd_ready, cell_will_write, snap}
            !== {3'b010, 8'h05}) begin
            n_bad++;
            $display("FAIL upd_idle: got v%b r%b we%b h%h want 0 1 0 05",
                rsp_valid, cmd_ready, cell_will_write, snap);
        end
    endtask

    task automatic test_multi_hit();
        load_cells(8'b1010_0100);
        send(8'd1, 1'b1, 8'h10, 8'h20);
        n_cmp++;
        if (cell_will_write !== 1'b0) begin
            n_bad++;
            $display("FAIL multi_we: got %b want 0", cell_will_write);
        end
        step();
        step();
        n_cmp++;
        if ({rsp_valid, rsp_hit, rsp_cell, rsp_value, rsp_context,
             rsp_hit_count, rsp_op}
            !== {2'b11, 3'd2, 8'hA2, 8'hC2, 4'd3, 8'd1}) begin
            n_bad++;
            $display("FAIL multi_rsp: got v%b h%b c%0d %h %h n%0d op%0d",
                rsp_valid, rsp_hit, rsp_cell, rsp_value, rsp_context,
                rsp_hit_count, rsp_op);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_masked_nohit();
        int we_seen = 0;
        load_cells('0);
        send(8'd2, 1'b1, 8'h44, 8'h55);
        for (int c = 0; c < 3; c++) begin
            if (cell_will_write) we_seen++;
            if (c < 2) step();
        end
        n_cmp++;
        if (we_seen != 0) begin
            n_bad++;
            $display("FAIL masked_we: got %0d cycles want 0", we_seen);
        end
        n_cmp++;
        if ({rsp_valid, rsp_hit, rsp_cell, rsp_value, rsp_context,
             rsp_hit_count} !== {2'b10, 3'd0, 8'h00, 8'h00, 4'd0}) begin
            n_bad++;
            $display("FAIL nohit_rsp: got v%b h%b c%0d %h %h n%0d",
                rsp_valid, rsp_hit, rsp_cell, rsp_value, rsp_context,
                rsp_hit_count);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_illegal_backpressure();
        int unstable = 0;
        load_cells(8'hFF);
        send(8'h09, 1'b1, 8'h01, 8'h02);
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_hit, rsp_cell, rsp_value,
             rsp_context, rsp_hit_count, rsp_op, cell_will_write}
            !== {3'b110, 3'd0, 8'h00, 8'h00, 4'd0, 8'h09, 1'b0}) begin
            n_bad++;
            $display("FAIL illegal_rsp: got v%b e%b h%b c%0d %h %h n%0d %h w%b",
                rsp_valid, rsp_err, rsp_hit, rsp_cell, rsp_value,
                rsp_context, rsp_hit_count, rsp_op, cell_will_write);
        end
        for (int c = 0; c < 5; c++) begin
            step();
            if ({rsp_valid, rsp_err, cmd_ready, cell_will_write,
                 rsp_hit_count, rsp_op}
                !== {4'b1100, 4'd0, 8'h09}) unstable++;
        end
        n_cmp++;
        if (unstable != 0) begin
            n_bad++;
            $display("FAIL bp_hold: got %0d bad cycles want 0", unstable);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_cmp++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL bp_release: got v%b r%b want 0 1",
                rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_all_hit();
        load_cells(8'hFF);
        send(8'd7, 1'b0, 8'h00, 8'h00);
        step();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL allhit_early: got %b want 0", rsp_valid);
        end
        step();
        n_cmp++;
        if ({rsp_valid, rsp_hit, rsp_cell, rsp_value, rsp_hit_count}
            !== {2'b11, 3'd0, 8'hA0, 4'd8}) begin
            n_bad++;
            $display("FAIL allhit_rsp: got v%b h%b c%0d %h n%0d",
                rsp_valid, rsp_hit, rsp_cell, rsp_value, rsp_hit_count);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    // Ready and a new command in the same RESP cycle: only one edge passes
    task automatic test_back_to_back();
        int lat = -1;
        load_cells(8'b0100_0000);
        send(8'd4, 1'b1, 8'h66, 8'h77);
        step();
        step();
        rsp_ready   = 1'b1;
        cmd_valid   = 1'b1;
        cmd_op      = 8'd5;
        cmd_write   = 1'b1;
        cmd_handle  = 8'h99;
        step();
        rsp_ready = 1'b0;
        n_cmp++;
        if ({cmd_ready, cell_handle, cell_selector}
            !== {1'b1, 8'h66, 8'd4}) begin
            n_bad++;
            $display("FAIL b2b_noaccept: got r%b h%h s%0d want 1 66 4",
                cmd_ready, cell_handle, cell_selector);
        end
        step();
        cmd_valid = 1'b0;
        n_cmp++;
        if ({cell_handle, cell_selector, cell_will_write}
            !== {8'h99, 8'd5, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_issue: got h%h s%0d we%b want 99 5 0",
                cell_handle, cell_selector, cell_will_write);
        end
        for (int c = 1; c <= 6; c++) begin
            if (lat < 0 && rsp_valid) lat = c;
            if (lat < 0) step();
        end
        n_cmp++;
        if (lat != 3) begin
            n_bad++;
            $display("FAIL b2b_latency: got %0d want 3", lat);
        end
        n_cmp++;
        if ({rsp_cell, rsp_value, rsp_hit_count} !== {3'd6, 8'hA6, 4'd1})
        begin
            n_bad++;
            $display("FAIL b2b_rsp: got c%0d %h n%0d want 6 a6 1",
                rsp_cell, rsp_value, rsp_hit_count);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_issue();
        load_cells(8'h01);
        send(8'd3, 1'b1, 8'h5A, 8'hA5);
        n_cmp++;
        if (cell_will_write !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_pre_we: got %b want 1", cell_will_write);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cell_will_write, cell_handle, cell_inserted_value,
             cell_selector, rsp_valid, cmd_ready} !== 27'd0) begin
            n_bad++;
            $display("FAIL rst_async: got we%b h%h v%h s%h rv%b r%b",
                cell_will_write, cell_handle, cell_inserted_value,
                cell_selector, rsp_valid, cmd_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        step();
        n_cmp++;
        if ({cmd_ready, rsp_valid, cell_will_write} !== 3'b100) begin
            n_bad++;
            $display("FAIL rst_after: got r%b v%b we%b want 1 0 0",
                cmd_ready, rsp_valid, cell_will_write);
        end
    endtask

    initial begin
        test_reset();
        test_update_write();
        test_multi_hit();
        test_masked_nohit();
        test_illegal_backpressure();
        test_all_hit();
        test_back_to_back();
        test_reset_mid_issue();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
            n_cmp, n_bad);
        $finish;
    end

endmodule
